// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Architectural constants: datapath width and the memory macro's read latency
  localparam int MEM_XLEN         = 32;
  localparam int MEM_READ_LATENCY = 1;

  // Byte-lane write mask width
  localparam int MEM_MASK_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_READ_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_LS
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, LS) and memory-macro signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req until their *_done pulse.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN = MEM_XLEN
);
  // Instruction fetch requester (read-only)
  logic                  if_req;
  logic [XLEN-1:0]       if_addr;
  logic                  if_done;
  logic [XLEN-1:0]       if_r_data;
  // Load/store requester
  logic                  ls_req;
  logic                  ls_we;
  logic [XLEN-1:0]       ls_addr;
  logic [XLEN-1:0]       ls_w_data;
  logic [MEM_MASK_W-1:0] ls_w_mask;
  logic                  ls_done;
  logic [XLEN-1:0]       ls_r_data;
  // Memory macro side
  logic [XLEN-1:0]       mem_addr;
  logic                  mem_w_en;
  logic [MEM_MASK_W-1:0] mem_w_mask;
  logic [XLEN-1:0]       mem_w_data;
  logic [XLEN-1:0]       mem_r_data;
  // Status
  logic                  busy;

  // Environment view: drives requests and memory read data
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_w_data, ls_w_mask, mem_r_data,
    input  if_done, if_r_data, ls_done, ls_r_data,
    input  mem_addr, mem_w_en, mem_w_mask, mem_w_data, busy
  );

  // Arbiter view
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_w_data, ls_w_mask, mem_r_data,
    output if_done, if_r_data, ls_done, ls_r_data,
    output mem_addr, mem_w_en, mem_w_mask, mem_w_data, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF (read) and LS (read/write), LS first.
// Latency: writes complete in the grant cycle; reads complete READ_LATENCY cycles after grant.
// Backpressure: requesters hold req until done; one access at a time. Option: MEM_ARB_ANTI_STARVE_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN         = MEM_XLEN,
  parameter int READ_LATENCY = MEM_READ_LATENCY,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave io_port
);

  localparam int               CNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject configurations the read sequencing cannot express
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: READ_LATENCY must be at least 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t       r_state, w_state_nxt;
  mem_owner_t       r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]  r_addr, w_addr_nxt;
  logic [XLEN-1:0]  r_if_data, r_ls_data;
  logic             w_grant_if, w_grant_ls;
  logic             w_if_rd_done, w_ls_rd_done;

`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt >= STV_W'(STARVE_LIMIT));
`endif

  // Priority select, evaluated only while the port is free
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    if (r_state == ARB_IDLE) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
      if (io_port.if_req && w_starved) begin
        w_grant_if = 1'b1;
      end else if (io_port.ls_req) begin
        w_grant_ls = 1'b1;
      end else if (io_port.if_req) begin
        w_grant_if = 1'b1;
      end
`else
      if (io_port.ls_req) begin
        w_grant_ls = 1'b1;
      end else if (io_port.if_req) begin
        w_grant_if = 1'b1;
      end
`endif
    end
  end

`ifdef MEM_ARB_ANTI_STARVE_EN
  // Count LS wins that bypassed a waiting IF; any IF win or an idle IF clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!io_port.if_req || w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ls && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + STV_W'(1);
    end
  end
`endif

  // Next state and memory/completion outputs; everything is forced low during reset
  always_comb begin
    w_state_nxt        = r_state;
    w_owner_nxt        = r_owner;
    w_cnt_nxt          = r_cnt;
    w_addr_nxt         = r_addr;
    w_if_rd_done       = 1'b0;
    w_ls_rd_done       = 1'b0;
    io_port.mem_addr   = '0;
    io_port.mem_w_en   = 1'b0;
    io_port.mem_w_mask = '0;
    io_port.mem_w_data = '0;
    io_port.if_done    = 1'b0;
    io_port.ls_done    = 1'b0;
    io_port.busy       = 1'b0;
    if (!reset) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_ls) begin
            io_port.mem_addr = io_port.ls_addr;
            if (io_port.ls_we) begin
              // Writes retire in the grant cycle; the port stays free for the next one
              io_port.mem_w_en   = 1'b1;
              io_port.mem_w_mask = io_port.ls_w_mask;
              io_port.mem_w_data = io_port.ls_w_data;
              io_port.ls_done    = 1'b1;
            end else begin
              w_state_nxt = ARB_READ_WAIT;
              w_owner_nxt = OWNER_LS;
              w_cnt_nxt   = CNT_LOAD;
              w_addr_nxt  = io_port.ls_addr;
            end
          end else if (w_grant_if) begin
            io_port.mem_addr = io_port.if_addr;
            w_state_nxt      = ARB_READ_WAIT;
            w_owner_nxt      = OWNER_IF;
            w_cnt_nxt        = CNT_LOAD;
            w_addr_nxt       = io_port.if_addr;
          end
        end
        ARB_READ_WAIT: begin
          io_port.busy     = 1'b1;
          io_port.mem_addr = r_addr;
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
          // Counter reads 1 in the cycle mem_r_data becomes valid
          if (r_cnt <= CNT_ONE) begin
            w_if_rd_done    = (r_owner == OWNER_IF);
            w_ls_rd_done    = (r_owner == OWNER_LS);
            io_port.if_done = w_if_rd_done;
            io_port.ls_done = w_ls_rd_done;
            w_state_nxt     = ARB_IDLE;
            w_owner_nxt     = OWNER_NONE;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
          w_owner_nxt = OWNER_NONE;
        end
      endcase
    end
  end

  // Owner sees live memory data on its done cycle, everyone else the last delivered word
  assign io_port.if_r_data = w_if_rd_done ? io_port.mem_r_data : r_if_data;
  assign io_port.ls_r_data = w_ls_rd_done ? io_port.mem_r_data : r_ls_data;

  // Sequencer state: FSM, owner, latency counter and latched read address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= OWNER_NONE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Keep the last read word delivered to each requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      if (w_if_rd_done) begin
        r_if_data <= io_port.mem_r_data;
      end
      if (w_ls_rd_done) begin
        r_ls_data <= io_port.mem_r_data;
      end
    end
  end

  // Requesters must keep address and direction steady until served
  a_ls_stable: assert property (@(posedge clock) disable iff (reset)
    ($past(io_port.ls_req) && io_port.ls_req && !$past(io_port.ls_done))
      |-> ($stable(io_port.ls_addr) && $stable(io_port.ls_we)));

  a_if_stable: assert property (@(posedge clock) disable iff (reset)
    ($past(io_port.if_req) && io_port.if_req && !$past(io_port.if_done))
      |-> $stable(io_port.if_addr));

  // The port never writes while a read owns it
  a_no_wr_in_wait: assert property (@(posedge clock) disable iff (reset)
    (r_state == ARB_READ_WAIT) |-> !io_port.mem_w_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with READ_LATENCY=1 and READ_LATENCY=3 instances.
// Latency: checks done-pulse timing against hand-computed cycle numbers.
// Backpressure: requests held until done; contention and starvation exercised.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.XLEN(32)) bus1 ();
  mem_port_arbiter_if #(.XLEN(32)) bus3 ();

  mem_port_arbiter #(.XLEN(32), .READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clock   (clock),
    .reset   (reset),
    .io_port (bus1)
  );

  mem_port_arbiter #(.XLEN(32), .READ_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clock   (clock),
    .reset   (reset),
    .io_port (bus3)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    bus1.ls_addr = '0; bus1.ls_w_data = '0; bus1.ls_w_mask = '0; bus1.mem_r_data = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.ls_req = 1'b0; bus3.ls_we = 1'b0;
    bus3.ls_addr = '0; bus3.ls_w_data = '0; bus3.ls_w_mask = '0; bus3.mem_r_data = '0;
  endtask

  initial begin
    clear_inputs();
    #1 reset = 1'b1;
    // Outputs held low by reset even with a write request pending
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 32'h44;
    bus1.ls_w_data = 32'hA5A5A5A5; bus1.ls_w_mask = 4'hF;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h88;
    #2;
    expect_eq("rst_mem_w_en",  32'(bus1.mem_w_en), 0);
    expect_eq("rst_mem_addr",  bus1.mem_addr, 0);
    expect_eq("rst_mem_w_data", bus1.mem_w_data, 0);
    expect_eq("rst_ls_done",   32'(bus1.ls_done), 0);
    expect_eq("rst_busy",      32'(bus1.busy), 0);
    expect_eq("rst_if_r_data", bus1.if_r_data, 0);
    expect_eq("rst_ls_r_data", bus1.ls_r_data, 0);
    clear_inputs();
    next_cyc();
    next_cyc();
    reset = 1'b0;

    // IF-only read, latency 1
    next_cyc();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
    settle();
    expect_eq("if_rd_grant_addr", bus1.mem_addr, 32'h100);
    expect_eq("if_rd_grant_busy", 32'(bus1.busy), 0);
    expect_eq("if_rd_grant_done", 32'(bus1.if_done), 0);
    next_cyc();
    bus1.mem_r_data = 32'h00500093;
    settle();
    expect_eq("if_rd_busy",   32'(bus1.busy), 1);
    expect_eq("if_rd_done",   32'(bus1.if_done), 1);
    expect_eq("if_rd_data",   bus1.if_r_data, 32'h00500093);
    expect_eq("if_rd_hold",   bus1.mem_addr, 32'h100);
    expect_eq("if_rd_ls_done", 32'(bus1.ls_done), 0);
    next_cyc();
    bus1.if_req = 1'b0; bus1.mem_r_data = 32'hFFFFFFFF;
    settle();
    expect_eq("if_rd_busy_end", 32'(bus1.busy), 0);
    expect_eq("if_rd_done_end", 32'(bus1.if_done), 0);
    expect_eq("if_rd_data_hold", bus1.if_r_data, 32'h00500093);

    // LS writes back to back, second with an empty mask
    next_cyc();
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 32'h2000;
    bus1.ls_w_data = 32'hDEADBEEF; bus1.ls_w_mask = 4'b0011;
    settle();
    expect_eq("wr_w_en",   32'(bus1.mem_w_en), 1);
    expect_eq("wr_done",   32'(bus1.ls_done), 1);
    expect_eq("wr_mask",   32'(bus1.mem_w_mask), 32'h3);
    expect_eq("wr_data",   bus1.mem_w_data, 32'hDEADBEEF);
    expect_eq("wr_addr",   bus1.mem_addr, 32'h2000);
    expect_eq("wr_busy",   32'(bus1.busy), 0);
    next_cyc();
    bus1.ls_addr = 32'h2008; bus1.ls_w_data = 32'h12345678; bus1.ls_w_mask = 4'b0000;
    settle();
    expect_eq("wr0_w_en",  32'(bus1.mem_w_en), 1);
    expect_eq("wr0_done",  32'(bus1.ls_done), 1);
    expect_eq("wr0_mask",  32'(bus1.mem_w_mask), 0);
    expect_eq("wr0_addr",  bus1.mem_addr, 32'h2008);
    next_cyc();
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    settle();
    expect_eq("wr_end_w_en", 32'(bus1.mem_w_en), 0);
    expect_eq("wr_end_done", 32'(bus1.ls_done), 0);
    expect_eq("wr_ls_r_data", bus1.ls_r_data, 0);

    // Contention: LS read wins, IF follows
    next_cyc();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h300;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 32'h2004;
    settle();
    expect_eq("cont_grant_addr", bus1.mem_addr, 32'h2004);
    expect_eq("cont_grant_if_done", 32'(bus1.if_done), 0);
    next_cyc();
    bus1.mem_r_data = 32'h11112222;
    settle();
    expect_eq("cont_ls_done", 32'(bus1.ls_done), 1);
    expect_eq("cont_ls_if_done", 32'(bus1.if_done), 0);
    expect_eq("cont_ls_data", bus1.ls_r_data, 32'h11112222);
    expect_eq("cont_ls_addr", bus1.mem_addr, 32'h2004);
    next_cyc();
    bus1.ls_req = 1'b0; bus1.mem_r_data = 32'h0;
    settle();
    expect_eq("cont_if_grant_addr", bus1.mem_addr, 32'h300);
    expect_eq("cont_if_grant_busy", 32'(bus1.busy), 0);
    expect_eq("cont_ls_data_hold", bus1.ls_r_data, 32'h11112222);
    next_cyc();
    bus1.mem_r_data = 32'h33334444;
    settle();
    expect_eq("cont_if_done", 32'(bus1.if_done), 1);
    expect_eq("cont_if_ls_done", 32'(bus1.ls_done), 0);
    expect_eq("cont_if_data", bus1.if_r_data, 32'h33334444);
    expect_eq("cont_if_ls_hold", bus1.ls_r_data, 32'h11112222);
    next_cyc();
    bus1.if_req = 1'b0;
    settle();
    expect_eq("cont_end_busy", 32'(bus1.busy), 0);

    // Reset in the middle of a latency-3 read
    next_cyc();
    bus3.if_req = 1'b1; bus3.if_addr = 32'h400;
    settle();
    expect_eq("rstrd_grant_addr", bus3.mem_addr, 32'h400);
    next_cyc();
    settle();
    expect_eq("rstrd_busy_pre", 32'(bus3.busy), 1);
    #1 reset = 1'b1;
    #1;
    expect_eq("rstrd_busy_now", 32'(bus3.busy), 0);
    expect_eq("rstrd_addr_now", bus3.mem_addr, 0);
    bus3.if_req = 1'b0; bus3.mem_r_data = 32'hCAFE0001;
    next_cyc();
    reset = 1'b0;
    settle();
    expect_eq("rstrd_no_done", 32'(bus3.if_done), 0);
    expect_eq("rstrd_idle_busy", 32'(bus3.busy), 0);
    next_cyc();
    bus3.if_req = 1'b1; bus3.if_addr = 32'h500;
    settle();
    expect_eq("rstrd_new_addr", bus3.mem_addr, 32'h500);
    expect_eq("rstrd_new_busy", 32'(bus3.busy), 0);
    for (int i = 1; i < 3; i++) begin
      next_cyc();
      settle();
      expect_eq("rstrd_wait_busy", 32'(bus3.busy), 1);
      expect_eq("rstrd_wait_done", 32'(bus3.if_done), 0);
      expect_eq("rstrd_wait_addr", bus3.mem_addr, 32'h500);
    end
    next_cyc();
    bus3.mem_r_data = 32'h00000055;
    settle();
    expect_eq("rstrd_done", 32'(bus3.if_done), 1);
    expect_eq("rstrd_data", bus3.if_r_data, 32'h55);
    next_cyc();
    bus3.if_req = 1'b0;
    settle();
    expect_eq("rstrd_end_busy", 32'(bus3.busy), 0);

    // Continuous LS writes with IF waiting
    next_cyc();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h600;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 32'h2100;
    bus1.ls_w_data = 32'h0BADF00D; bus1.ls_w_mask = 4'hF;
`ifdef MEM_ARB_ANTI_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      settle();
      expect_eq("stv_ls_done", 32'(bus1.ls_done), 1);
      expect_eq("stv_ls_addr", bus1.mem_addr, 32'h2100);
      next_cyc();
    end
    settle();
    expect_eq("stv_if_grant_addr", bus1.mem_addr, 32'h600);
    expect_eq("stv_if_grant_ls_done", 32'(bus1.ls_done), 0);
    expect_eq("stv_if_grant_w_en", 32'(bus1.mem_w_en), 0);
    next_cyc();
    bus1.mem_r_data = 32'h00000066;
    settle();
    expect_eq("stv_if_done", 32'(bus1.if_done), 1);
    expect_eq("stv_if_data", bus1.if_r_data, 32'h66);
    expect_eq("stv_wait_ls_done", 32'(bus1.ls_done), 0);
    next_cyc();
    bus1.if_req = 1'b0;
    settle();
    expect_eq("stv_ls_resume", 32'(bus1.ls_done), 1);
    next_cyc();
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
`else
    for (int i = 0; i < 8; i++) begin
      settle();
      expect_eq("prio_ls_done", 32'(bus1.ls_done), 1);
      expect_eq("prio_if_done", 32'(bus1.if_done), 0);
      expect_eq("prio_ls_addr", bus1.mem_addr, 32'h2100);
      next_cyc();
    end
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    settle();
    expect_eq("prio_if_grant_addr", bus1.mem_addr, 32'h600);
    next_cyc();
    bus1.mem_r_data = 32'h00000066;
    settle();
    expect_eq("prio_if_done_late", 32'(bus1.if_done), 1);
    next_cyc();
    bus1.if_req = 1'b0;
`endif
    settle();
    expect_eq("stv_end_busy", 32'(bus1.busy), 0);

    // IF drops its request while its latency-3 read is in flight
    next_cyc();
    bus3.if_req = 1'b1; bus3.if_addr = 32'h700;
    settle();
    expect_eq("drop_grant_addr", bus3.mem_addr, 32'h700);
    next_cyc();
    bus3.if_req = 1'b0;
    settle();
    expect_eq("drop_busy1", 32'(bus3.busy), 1);
    expect_eq("drop_done1", 32'(bus3.if_done), 0);
    next_cyc();
    settle();
    expect_eq("drop_done2", 32'(bus3.if_done), 0);
    next_cyc();
    bus3.mem_r_data = 32'h00000077;
    settle();
    expect_eq("drop_done3", 32'(bus3.if_done), 1);
    expect_eq("drop_data",  bus3.if_r_data, 32'h77);
    next_cyc();
    bus3.ls_req = 1'b1; bus3.ls_we = 1'b1; bus3.ls_addr = 32'h3000;
    bus3.ls_w_data = 32'h01020304; bus3.ls_w_mask = 4'b1000;
    settle();
    expect_eq("drop_idle_busy", 32'(bus3.busy), 0);
    expect_eq("drop_idle_wr_done", 32'(bus3.ls_done), 1);
    expect_eq("drop_idle_wr_mask", 32'(bus3.mem_w_mask), 32'h8);
    next_cyc();
    bus3.ls_req = 1'b0; bus3.ls_we = 1'b0;
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
